dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-ported, byte-lane-writable data memory between two requesters: the CPU MEM stage (load/store) and a debug/loader port that lets a host preload or dump memory while the pipeline runs. CPU has fixed priority; a starvation counter guarantees the debug port one slot after a bounded wait. The block stalls the CPU when it loses arbitration and routes each synchronous read response to the requester that issued it. It sits between the pipeline's MEM stage and the data memory instance.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width; byte lanes = DATA_W/8.
- `STARVE_LIMIT`, 4: consecutive denied debug cycles before debug is forced a slot (≥1).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request, held until not stalled.
- `cpu_we` in 1: 1 = store.
- `cpu_addr` in ADDR_W: byte address.
- `cpu_wdata` in DATA_W: store data.
- `cpu_be` in DATA_W/8: byte enables for stores.
- `cpu_stall` out 1: request not accepted this cycle.
- `cpu_rvalid` out 1: read response valid.
- `cpu_rdata` out DATA_W: read data.
- `cpu_err` out 1: error response (with cpu_rvalid).
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_be`: as CPU equivalents, debug port.
- `dbg_gnt` out 1: debug request accepted this cycle.
- `dbg_rvalid`, `dbg_rdata`, `dbg_err` out: debug response.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out DATA_W/8: per-lane write strobes (0 for reads).
- `mem_addr` out ADDR_W: word-aligned byte address.
- `mem_wdata` out DATA_W.
- `mem_rdata` in DATA_W: valid one cycle after `mem_en` read.

## Operation
- Grant (combinational, same cycle): `cnt == STARVE_LIMIT` and `dbg_req` → debug; else `cpu_req` → CPU; else `dbg_req` → debug.
- `cpu_stall = cpu_req & ~cpu_granted`; `dbg_gnt = dbg_req & dbg_granted`.
- Starvation counter `cnt`: +1 each cycle `dbg_req & ~dbg_gnt`, saturates at STARVE_LIMIT; clears when `dbg_gnt` or `~dbg_req`.
- Access check on granted request: `addr[1:0] != 0` or `addr >= DATA_MEM_SIZE` → error: `mem_en=0`, request still counts as accepted, error response next cycle.
- Valid access: `mem_en=1`, `mem_addr=addr`, `mem_we = we ? be : 0`, `mem_wdata=wdata`.
- Response register (owner, is_read, is_err), written every cycle: next cycle drives `*_rvalid` of the owner for reads and errors only; stores produce no response. Error response: `*_rdata=0`, `*_err=1`. Non-owner `rdata` = 0.
- Simultaneous requests with `cnt < STARVE_LIMIT`: CPU wins. Continuous contention yields a repeating STARVE_LIMIT CPU / 1 debug pattern.

## Timing
- Grant/stall/mem_* outputs: zero-latency combinational from requests and `cnt`.
- Read latency: 1 cycle (`rvalid` in N+1 for accept in N); one access per cycle, back-to-back fully pipelined.
- Reset (asynchronous, `rst_n` low): `cnt=0`, response register cleared; all outputs 0 while `rst_n` low (grants gated by `rst_n`). Reset mid-read drops the pending response; no `rvalid` after release.
- Write visible to a read accepted the following cycle (memory write-first is not required).

## Structure
- `DATA_MEM_SIZE` from `SYSTEM_DEF.vh`; add `DMEM_STARVE_LIMIT` default there.
- Owner encoding (`OWN_CPU`, `OWN_DBG`) as local constants.
- One natural sub-module: `dmem_addr_check` (alignment + range → error), reused by the instruction-side loader.

## Test plan
- CPU read 0x10, mem word 0xDEADBEEF → cycle N `mem_en=1`, `mem_addr=0x10`, no stall; N+1 `cpu_rvalid=1`, `cpu_rdata=0xDEADBEEF`.
- Both requesting continuously, LIMIT=4 → `dbg_gnt` and `cpu_stall` high together on cycles 5, 10, 15; no other stalls.
- Debug store 0x12345678 be=0011 to 0x20 over 0xAAAAAAAA, then CPU read 0x20 → 0xAAAA5678.
- CPU read at DATA_MEM_SIZE and at 0x22 → `mem_en=0`, next cycle `cpu_rvalid=1`, `cpu_err=1`, `cpu_rdata=0`.
- CPU read 0x10 (N) then debug read 0x20 (N+1) → `cpu_rvalid` only at N+1, `dbg_rvalid` only at N+2, correct data each.
- `rst_n` low at N+1 after read accepted at N → no `cpu_rvalid`; after release `cnt=0`, first contended debug grant after 4 denied cycles.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter and its address checker.
// Holds the memory size, the default starvation limit and the response-owner encoding.
package dmem_arbiter_pkg;

   localparam int DATA_MEM_SIZE     = 32'h0000_1000;
   localparam int DMEM_STARVE_LIMIT = 32'd4;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DBG = 1'b1
   } owner_e;

   // One-cycle-delayed response bookkeeping: who issued it and what kind it was
   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   err;
   } rsp_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug and memory-side signals around the data-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic                  cpu_req;
   logic                  cpu_we;
   logic [ADDR_W-1:0]     cpu_addr;
   logic [DATA_W-1:0]     cpu_wdata;
   logic [DATA_W/8-1:0]   cpu_be;
   logic                  cpu_stall;
   logic                  cpu_rvalid;
   logic [DATA_W-1:0]     cpu_rdata;
   logic                  cpu_err;

   logic                  dbg_req;
   logic                  dbg_we;
   logic [ADDR_W-1:0]     dbg_addr;
   logic [DATA_W-1:0]     dbg_wdata;
   logic [DATA_W/8-1:0]   dbg_be;
   logic                  dbg_gnt;
   logic                  dbg_rvalid;
   logic [DATA_W-1:0]     dbg_rdata;
   logic                  dbg_err;

   logic                  mem_en;
   logic [DATA_W/8-1:0]   mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
      output cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be,
      output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
      input  cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be,
      input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_addr_check.sv
// Flags accesses that are not word-aligned or fall beyond the end of memory.
// Kept standalone so the instruction-side loader can share the same rule.
module dmem_addr_check #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MEM_SIZE = 32'h0000_1000
) (
   input  logic [ADDR_W-1:0] addr_i,
   output logic              err_o
);

   localparam int OFS_W = $clog2(DATA_W / 8);

   logic misaligned_s;
   logic out_of_range_s;

   assign misaligned_s   = (addr_i[OFS_W-1:0] != {OFS_W{1'b0}});
   assign out_of_range_s = (addr_i >= ADDR_W'(MEM_SIZE));
   assign err_o          = misaligned_s | out_of_range_s;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU has fixed priority, the debug port is forced
// a slot after STARVE_LIMIT consecutive denials; read responses go back to their issuer.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_arbiter_if.slave bus
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   rsp_t              rsp_q, rsp_d;

   logic              starved_s;
   logic              cpu_sel_s;
   logic              dbg_sel_s;
   logic              granted_s;
   logic              acc_we_s;
   logic [ADDR_W-1:0] acc_addr_s;
   logic [DATA_W-1:0] acc_wdata_s;
   logic [BE_W-1:0]   acc_be_s;
   logic              chk_err_s;

   assign starved_s = (cnt_q == CNT_W'(STARVE_LIMIT));
   assign granted_s = cpu_sel_s | dbg_sel_s;

   // Grant selection; everything is gated off while reset is asserted
   always_comb begin
      cpu_sel_s = 1'b0;
      dbg_sel_s = 1'b0;
      if (rst_n && bus.dbg_req && (starved_s || !bus.cpu_req)) begin
         dbg_sel_s = 1'b1;
      end else if (rst_n && bus.cpu_req) begin
         cpu_sel_s = 1'b1;
      end else begin
         cpu_sel_s = 1'b0;
         dbg_sel_s = 1'b0;
      end
   end

   // Steer the winning requester's fields onto the shared access path
   always_comb begin
      acc_we_s    = 1'b0;
      acc_addr_s  = {ADDR_W{1'b0}};
      acc_wdata_s = {DATA_W{1'b0}};
      acc_be_s    = {BE_W{1'b0}};
      if (dbg_sel_s) begin
         acc_we_s    = bus.dbg_we;
         acc_addr_s  = bus.dbg_addr;
         acc_wdata_s = bus.dbg_wdata;
         acc_be_s    = bus.dbg_be;
      end else begin
         acc_we_s    = bus.cpu_we;
         acc_addr_s  = bus.cpu_addr;
         acc_wdata_s = bus.cpu_wdata;
         acc_be_s    = bus.cpu_be;
      end
   end

   dmem_addr_check #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MEM_SIZE (DATA_MEM_SIZE)
   ) u_addr_check (
      .addr_i (acc_addr_s),
      .err_o  (chk_err_s)
   );

   // Memory port drive and requester handshakes; a rejected access still counts as accepted
   always_comb begin
      bus.cpu_stall = rst_n & bus.cpu_req & ~cpu_sel_s;
      bus.dbg_gnt   = dbg_sel_s;
      bus.mem_en    = 1'b0;
      bus.mem_we    = {BE_W{1'b0}};
      bus.mem_addr  = {ADDR_W{1'b0}};
      bus.mem_wdata = {DATA_W{1'b0}};
      if (granted_s && !chk_err_s) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = acc_we_s ? acc_be_s : {BE_W{1'b0}};
         bus.mem_addr  = acc_addr_s;
         bus.mem_wdata = acc_wdata_s;
      end else begin
         bus.mem_en    = 1'b0;
      end
   end

   // Next-state for the starvation counter and the response register
   always_comb begin
      cnt_d = {CNT_W{1'b0}};
      if (bus.dbg_req && !dbg_sel_s) begin
         if (starved_s) begin
            cnt_d = cnt_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = {CNT_W{1'b0}};
      end

      // Stores that pass the check are silent; reads and any error get a response
      rsp_d.valid = granted_s & (~acc_we_s | chk_err_s);
      rsp_d.owner = dbg_sel_s ? OWN_DBG : OWN_CPU;
      rsp_d.err   = granted_s & chk_err_s;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CNT_W{1'b0}};
         rsp_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         rsp_q <= rsp_d;
      end
   end

   // Route the registered response to its owner; the other side sees zeros
   always_comb begin
      bus.cpu_rvalid = 1'b0;
      bus.cpu_err    = 1'b0;
      bus.cpu_rdata  = {DATA_W{1'b0}};
      bus.dbg_rvalid = 1'b0;
      bus.dbg_err    = 1'b0;
      bus.dbg_rdata  = {DATA_W{1'b0}};
      case (rsp_q.owner)
         OWN_CPU: begin
            bus.cpu_rvalid = rsp_q.valid;
            bus.cpu_err    = rsp_q.valid & rsp_q.err;
            bus.cpu_rdata  = (rsp_q.valid && !rsp_q.err) ? bus.mem_rdata : {DATA_W{1'b0}};
         end
         OWN_DBG: begin
            bus.dbg_rvalid = rsp_q.valid;
            bus.dbg_err    = rsp_q.valid & rsp_q.err;
            bus.dbg_rdata  = (rsp_q.valid && !rsp_q.err) ? bus.mem_rdata : {DATA_W{1'b0}};
         end
         default: begin
            bus.cpu_rvalid = 1'b0;
            bus.dbg_rvalid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written corner sequences and
// random traffic compared against a behavioural arbitration/memory model.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 4)      return 32'hDEAD_BEEF;
      else if (i == 8) return 32'hAAAA_AAAA;
      else             return {16'hC0DE, 16'(i)};
   endfunction

   // Synchronous single-port memory with byte-lane writes, one-cycle read latency
   logic [31:0] mem_arr [0:1023];
   logic [31:0] mem_rd_r;
   bit          mem_init_done = 1'b0;
   assign bus.mem_rdata = mem_rd_r;

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 1024; i++) mem_arr[i] <= init_word(i);
         mem_init_done <= 1'b1;
      end else if (bus.mem_en) begin
         if (bus.mem_we == 4'b0000) begin
            mem_rd_r <= mem_arr[bus.mem_addr[11:2]];
         end else begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_we[b]) mem_arr[bus.mem_addr[11:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model state
   int          denied = 0;
   logic [31:0] shadow [0:1023];
   bit          p_valid = 1'b0, p_dbg = 1'b0, p_err = 1'b0;
   logic [31:0] p_data  = 32'h0;

   task automatic model_check();
      bit          cwin, dwin, err, we;
      logic [31:0] a, wd;
      logic [3:0]  be;
      if (!rst_n) begin
         chk("rst_stall", bus.cpu_stall, 1'b0);
         chk("rst_gnt", bus.dbg_gnt, 1'b0);
         chk("rst_mem_en", bus.mem_en, 1'b0);
         chk("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
         chk("rst_dbg_rvalid", bus.dbg_rvalid, 1'b0);
         denied  = 0;
         p_valid = 1'b0;
      end else begin
         chk("m_cpu_rvalid", bus.cpu_rvalid, p_valid && !p_dbg);
         chk("m_cpu_err", bus.cpu_err, p_valid && !p_dbg && p_err);
         chk("m_cpu_rdata", bus.cpu_rdata, (p_valid && !p_dbg && !p_err) ? p_data : 32'h0);
         chk("m_dbg_rvalid", bus.dbg_rvalid, p_valid && p_dbg);
         chk("m_dbg_err", bus.dbg_err, p_valid && p_dbg && p_err);
         chk("m_dbg_rdata", bus.dbg_rdata, (p_valid && p_dbg && !p_err) ? p_data : 32'h0);
         cwin = 1'b0;
         dwin = 1'b0;
         if (bus.dbg_req && denied == LIM) dwin = 1'b1;
         else if (bus.cpu_req)            cwin = 1'b1;
         else if (bus.dbg_req)            dwin = 1'b1;
         a  = dwin ? bus.dbg_addr  : bus.cpu_addr;
         we = dwin ? bus.dbg_we    : bus.cpu_we;
         be = dwin ? bus.dbg_be    : bus.cpu_be;
         wd = dwin ? bus.dbg_wdata : bus.cpu_wdata;
         err = (cwin || dwin) && ((a % 4) != 0 || a >= 32'(DATA_MEM_SIZE));
         chk("m_stall", bus.cpu_stall, bus.cpu_req && !cwin);
         chk("m_gnt", bus.dbg_gnt, dwin);
         chk("m_mem_en", bus.mem_en, (cwin || dwin) && !err);
         if ((cwin || dwin) && !err) begin
            chk("m_mem_addr", bus.mem_addr, a);
            chk("m_mem_we", bus.mem_we, we ? be : 4'b0000);
            chk("m_mem_wdata", bus.mem_wdata, wd);
         end
         denied  = (bus.dbg_req && !dwin) ? ((denied < LIM) ? denied + 1 : LIM) : 0;
         p_valid = (cwin || dwin) && (!we || err);
         p_dbg   = dwin;
         p_err   = err;
         p_data  = err ? 32'h0 : shadow[a[11:2]];
         if ((cwin || dwin) && !err && we)
            for (int b = 0; b < 4; b++)
               if (be[b]) shadow[a[11:2]][8*b +: 8] = wd[8*b +: 8];
      end
   endtask

   task automatic to_negedge();
      @(negedge clk);
   endtask

   task automatic finish_cycle();
      model_check();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic [3:0] cb, input bit dr, input bit dw, input logic [31:0] da,
                        input logic [31:0] dd, input logic [3:0] db);
      bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd; bus.cpu_be = cb;
      bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd; bus.dbg_be = db;
   endtask

   function automatic logic [31:0] rand_addr();
      int k;
      k = $urandom_range(0, 9);
      if (k == 0)      return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else if (k == 1) return 32'(DATA_MEM_SIZE) + (32'($urandom_range(0, 255)) << 2);
      else             return 32'($urandom_range(0, 63)) << 2;
   endfunction

   typedef struct {
      bit cr, cw; logic [31:0] ca, cd; logic [3:0] cb;
      bit dr, dw; logic [31:0] da, dd; logic [3:0] db;
      bit s, g, en; logic [31:0] ma; logic [3:0] mw;
      bit crv, cerr; logic [31:0] crd;
      bit drv, derr; logic [31:0] drd;
   } vec_t;

   vec_t tbl [11];

   initial begin
      // Row fields: cpu{req,we,addr,wdata,be} dbg{...} exp{stall,gnt,en,addr,we} cpu_rsp{v,err,data} dbg_rsp{v,err,data}
      tbl[0]  = '{1'b0,1'b0,32'h0,32'h0,4'h0,          1'b0,1'b0,32'h0,32'h0,4'h0,          1'b0,1'b0,1'b0,32'h0,4'h0,  1'b0,1'b0,32'h0,          1'b0,1'b0,32'h0};
      tbl[1]  = '{1'b1,1'b0,32'h10,32'h0,4'h0,         1'b0,1'b0,32'h0,32'h0,4'h0,          1'b0,1'b0,1'b1,32'h10,4'h0, 1'b0,1'b0,32'h0,          1'b0,1'b0,32'h0};
      tbl[2]  = '{1'b0,1'b0,32'h0,32'h0,4'h0,          1'b1,1'b0,32'h20,32'h0,4'h0,         1'b0,1'b1,1'b1,32'h20,4'h0, 1'b1,1'b0,32'hDEADBEEF,   1'b0,1'b0,32'h0};
      tbl[3]  = '{1'b0,1'b0,32'h0,32'h0,4'h0,          1'b1,1'b1,32'h20,32'h12345678,4'h3,  1'b0,1'b1,1'b1,32'h20,4'h3, 1'b0,1'b0,32'h0,          1'b1,1'b0,32'hAAAAAAAA};
      tbl[4]  = '{1'b1,1'b0,32'h20,32'h0,4'h0,         1'b0,1'b0,32'h0,32'h0,4'h0,          1'b0,1'b0,1'b1,32'h20,4'h0, 1'b0,1'b0,32'h0,          1'b0,1'b0,32'h0};
      tbl[5]  = '{1'b1,1'b0,32'h1000,32'h0,4'h0,       1'b0,1'b0,32'h0,32'h0,4'h0,          1'b0,1'b0,1'b0,32'h0,4'h0,  1'b1,1'b0,32'hAAAA5678,   1'b0,1'b0,32'h0};
      tbl[6]  = '{1'b1,1'b0,32'h22,32'h0,4'h0,         1'b0,1'b0,32'h0,32'h0,4'h0,          1'b0,1'b0,1'b0,32'h0,4'h0,  1'b1,1'b1,32'h0,          1'b0,1'b0,32'h0};
      tbl[7]  = '{1'b1,1'b1,32'h30,32'hCAFEF00D,4'hF,  1'b0,1'b0,32'h0,32'h0,4'h0,          1'b0,1'b0,1'b1,32'h30,4'hF, 1'b1,1'b1,32'h0,          1'b0,1'b0,32'h0};
      tbl[8]  = '{1'b1,1'b0,32'h40,32'h0,4'h0,         1'b1,1'b0,32'h44,32'h0,4'h0,         1'b0,1'b0,1'b1,32'h40,4'h0, 1'b0,1'b0,32'h0,          1'b0,1'b0,32'h0};
      tbl[9]  = '{1'b0,1'b0,32'h0,32'h0,4'h0,          1'b1,1'b1,32'h45,32'h0,4'hF,         1'b0,1'b1,1'b0,32'h0,4'h0,  1'b1,1'b0,32'hC0DE0010,   1'b0,1'b0,32'h0};
      tbl[10] = '{1'b0,1'b0,32'h0,32'h0,4'h0,          1'b0,1'b0,32'h0,32'h0,4'h0,          1'b0,1'b0,1'b0,32'h0,4'h0,  1'b0,1'b0,32'h0,          1'b1,1'b1,32'h0};

      for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);

      // Requests held high during reset must not leak through
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      repeat (2) begin
         to_negedge();
         finish_cycle();
      end
      rst_n = 1'b1;

      for (int r = 0; r < 11; r++) begin
         drive(tbl[r].cr, tbl[r].cw, tbl[r].ca, tbl[r].cd, tbl[r].cb,
               tbl[r].dr, tbl[r].dw, tbl[r].da, tbl[r].dd, tbl[r].db);
         to_negedge();
         chk($sformatf("v%0d_stall", r), bus.cpu_stall, tbl[r].s);
         chk($sformatf("v%0d_gnt", r), bus.dbg_gnt, tbl[r].g);
         chk($sformatf("v%0d_mem_en", r), bus.mem_en, tbl[r].en);
         if (tbl[r].en) chk($sformatf("v%0d_mem_addr", r), bus.mem_addr, tbl[r].ma);
         chk($sformatf("v%0d_mem_we", r), bus.mem_we, tbl[r].mw);
         chk($sformatf("v%0d_cpu_rvalid", r), bus.cpu_rvalid, tbl[r].crv);
         chk($sformatf("v%0d_cpu_err", r), bus.cpu_err, tbl[r].cerr);
         chk($sformatf("v%0d_cpu_rdata", r), bus.cpu_rdata, tbl[r].crd);
         chk($sformatf("v%0d_dbg_rvalid", r), bus.dbg_rvalid, tbl[r].drv);
         chk($sformatf("v%0d_dbg_err", r), bus.dbg_err, tbl[r].derr);
         chk($sformatf("v%0d_dbg_rdata", r), bus.dbg_rdata, tbl[r].drd);
         finish_cycle();
      end

      // Continuous contention: debug forced in on every fifth cycle
      drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      for (int c = 1; c <= 15; c++) begin
         to_negedge();
         chk($sformatf("contend%0d_gnt", c), bus.dbg_gnt, (c % 5) == 0);
         chk($sformatf("contend%0d_stall", c), bus.cpu_stall, (c % 5) == 0);
         finish_cycle();
      end

      // Reset landing one cycle after an accepted read drops its response
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      to_negedge();
      finish_cycle();
      drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      to_negedge();
      chk("rst_seq_accept", bus.mem_en, 1'b1);
      finish_cycle();
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      to_negedge();
      chk("rst_seq_rvalid", bus.cpu_rvalid, 1'b0);
      finish_cycle();
      to_negedge();
      finish_cycle();
      rst_n = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         to_negedge();
         if (c == 1) chk("rel_rvalid", bus.cpu_rvalid, 1'b0);
         chk($sformatf("rel%0d_gnt", c), bus.dbg_gnt, c == 5);
         finish_cycle();
      end

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
         to_negedge();
         finish_cycle();
      end

      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) begin
         to_negedge();
         finish_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
